// File: rtl/datamem_pkg.sv
// Shared types and helpers for the datamem_dp data buffer.
// DATAMEM_PARITY_EN enables per-lane parity in the users of this package.
package datamem_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } datamem_state_e;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/datamem_if.sv
// Write/read port bundle for datamem_dp.
// DATAMEM_PARITY_EN adds the perr_inject test hook.
interface datamem_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int STRB_W = DATA_W / 8;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_perr;
`ifdef DATAMEM_PARITY_EN
  logic              perr_inject;
`endif

  modport master (
    output wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
`ifdef DATAMEM_PARITY_EN
    output perr_inject,
`endif
    input  rd_data, rd_valid, rd_perr
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
`ifdef DATAMEM_PARITY_EN
    input  perr_inject,
`endif
    output rd_data, rd_valid, rd_perr
  );

endinterface

// File: rtl/datamem_init_seq.sv
// Post-reset clear sequencer: sweeps every address once, then parks in RUN.
//   state   | meaning
//   ST_INIT | clearing word clr_addr, user ports blocked
//   ST_RUN  | normal operation, terminal until reset
module datamem_init_seq
  import datamem_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  datamem_state_e    state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr_we = 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_RUN;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      ST_RUN:  ;
      default: state_d = ST_INIT;
    endcase
  end

  assign clr_addr  = cnt_q;
  assign init_done = (state_q == ST_RUN);

endmodule

// File: rtl/datamem_dp.sv
// Simple dual-port data buffer: strobed writes, registered write-first reads, self-clear.
// DATAMEM_PARITY_EN adds per-lane even parity and the perr_inject hook.
module datamem_dp
  import datamem_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int STRB_W = DATA_W / BYTE_W
) (
  input  logic     clk,
  input  logic     rst_n,
  output logic     init_done,
  datamem_if.slave bus
);

  logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef DATAMEM_PARITY_EN
  logic [STRB_W-1:0] par_q [DEPTH];
  logic [STRB_W-1:0] wpar, rd_par;
  logic              inj;
`endif

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              we, hit, wr_inr, rd_inr, rd_go, perr;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata, rd_word;
  logic [STRB_W-1:0] wstrb;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d, rd_perr_q, rd_perr_d;

  datamem_init_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign wr_inr = (int'(bus.wr_addr) < DEPTH);
  assign rd_inr = (int'(bus.rd_addr) < DEPTH);
  assign rd_go  = init_done & bus.rd_en;

  // The clear sequencer owns the write port for the whole of INIT.
  always_comb begin
    we    = clr_we | (bus.wr_en & wr_inr);
    waddr = clr_we ? clr_addr : bus.wr_addr;
    wdata = clr_we ? '0 : bus.wr_data;
    wstrb = clr_we ? '1 : bus.wr_strb;
`ifdef DATAMEM_PARITY_EN
    inj  = bus.perr_inject & ~clr_we;
    wpar = '0;
    for (int i = 0; i < STRB_W; i++)
      wpar[i] = byte_parity(wdata[i*BYTE_W +: BYTE_W]) ^ inj;
`endif
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem_q[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
`ifdef DATAMEM_PARITY_EN
          par_q[waddr][i] <= wpar[i];
`endif
        end
      end
    end
  end

  // Write-first: strobed lanes of a same-edge write replace the stored bytes.
  always_comb begin
    hit     = we & (waddr == bus.rd_addr);
    rd_word = mem_q[bus.rd_addr];
    perr    = 1'b0;
`ifdef DATAMEM_PARITY_EN
    rd_par  = par_q[bus.rd_addr];
`endif
    for (int i = 0; i < STRB_W; i++) begin
      if (hit && wstrb[i]) begin
        rd_word[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
`ifdef DATAMEM_PARITY_EN
        rd_par[i] = wpar[i];
`endif
      end
    end
`ifdef DATAMEM_PARITY_EN
    for (int i = 0; i < STRB_W; i++)
      perr = perr | (byte_parity(rd_word[i*BYTE_W +: BYTE_W]) ^ rd_par[i]);
`endif
  end

  always_comb begin
    rd_valid_d = rd_go;
    rd_data_d  = rd_data_q;
    rd_perr_d  = 1'b0;
    if (rd_go) begin
      rd_data_d = rd_inr ? rd_word : '0;
      rd_perr_d = rd_inr & perr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_perr_q  <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_perr_q  <= rd_perr_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_perr  = rd_perr_q;

endmodule

// File: doc/datamem_dp.md
Name: datamem_dp

Overview:
- Parametrised successor to the 8-bit scratch data memory: a true-clocked simple dual-port RAM (one write port, one read port).
- Adds byte-lane write strobes, registered reads with a valid flag, write-first collision bypass and an automatic post-reset clear sequence.
- Sits behind the APB/I2C register and data paths as the shared data buffer.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width (derived; do not override).
- STRB_W, DATA_W/8, number of byte lanes (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- init_done  out  1  high once the clear sequence has completed.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write data.
- wr_strb  in  STRB_W  byte-lane enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read word address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse qualifying rd_data.
- rd_perr  out  1  parity error on the current read; qualified by rd_valid.

Behaviour:
- Reset (async assert, sync release): rd_data=0, rd_valid=0, rd_perr=0, init_done=0, FSM=INIT, clear counter=0.
- FSM states: INIT and RUN.
  - INIT: writes all-zero (and zero parity) to address = counter, one word per cycle. Counter increments; at counter==DEPTH-1 the FSM moves to RUN.
  - INIT lasts exactly DEPTH cycles after reset release. init_done rises on the first RUN cycle.
  - RUN is terminal until the next reset.
- During INIT: wr_en and rd_en are ignored. No array update, rd_valid stays 0.
- Write (RUN): at the clk edge with wr_en=1 and wr_addr<DEPTH, each lane with wr_strb[i]=1 is updated. Other lanes hold. wr_strb=0 is a legal no-op.
- Read (RUN): rd_en=1 at edge N gives rd_data and rd_valid=1 after edge N (1-cycle latency).
  - rd_valid is 0 in any cycle whose preceding edge had rd_en=0.
  - rd_data holds its last value when rd_valid=0.
  - Back-to-back reads give one word per cycle.
- Collision (wr_en and rd_en on the same address, same edge): write-first. rd_data returns the post-write word, i.e. new bytes on strobed lanes and old bytes elsewhere.
- Out of range (addr>=DEPTH, only possible when DEPTH is not a power of two):
  - Write is dropped.
  - Read returns rd_data=0 with rd_valid=1 and rd_perr=0.
- Reset mid-operation (INIT or RUN): outputs clear immediately and INIT restarts from address 0. Memory contents are re-cleared by the new INIT.
- Storage: array of DEPTH x DATA_W bits, plus STRB_W parity bits per word when the optional feature is compiled in. No reset on the array itself; only INIT clears it.

Optional Feature:
- Macro: DATAMEM_PARITY_EN.
- Defined:
  - Each lane stores even parity of its byte, written with that byte under the same strobe.
  - A read recomputes parity per lane. rd_perr=1 (with rd_valid) if any lane mismatches.
  - Adds input perr_inject (1 bit): when high during a write, the parity of the written lanes is stored inverted (test hook).
- Undefined:
  - No parity storage and no perr_inject port.
  - rd_perr is tied to 0.

Decomposition:
- Package datamem_pkg holds:
  - enum datamem_state_e {ST_INIT, ST_RUN}.
  - function byte_parity(byte).
  - constant BYTE_W=8.
- Sub-module datamem_init_seq: the INIT/RUN FSM plus clear counter. Outputs init_done, clr_we and clr_addr; the top muxes these onto the write port.

Test Plan (DATA_W=32, DEPTH=16 unless stated):
- Reset release -> init_done=0 for exactly 16 cycles, then 1. Reads of all 16 addresses then return 0x00000000, each with rd_valid one cycle after rd_en.
- Write 0xDEADBEEF to addr 3, strb=4'b1111; next cycle write 0x11223344 to addr 3, strb=4'b0101 -> read addr 3 returns 0xDE22BE44.
- Same edge: write addr 5 = 0xAABBCCDD (strb=4'b1100), read addr 5 (old 0x01020304) -> rd_data=0xAABB0304 on the next cycle.
- DEPTH=12: write addr 13 = 0xFFFFFFFF, then read addr 13 -> rd_data=0, rd_valid=1; read addr 11 is unchanged. Reads/writes issued during INIT -> no rd_valid and no array change.
- Assert rst_n=0 in RUN after writing addr 7 = 0x12345678 -> rd_valid and init_done drop immediately; after the new INIT, read addr 7 returns 0.
- DATAMEM_PARITY_EN: write addr 2 = 0x000000FF with perr_inject=1 -> read gives rd_perr=1. Rewrite with perr_inject=0 -> rd_perr=0.
